// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: requester handshakes, flush/stall controls and the registered
// write-back port feeding the ROB result push.
interface wb_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SrcW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    flush;
    logic                    rob_stall;
    logic                    wb_valid;
    logic [TAG_W-1:0]        wb_tag;
    logic [DATA_W-1:0]       wb_data;
    logic [SrcW-1:0]         wb_src;

    modport master (
        output req_valid, req_tag, req_data, flush, rob_stall,
        input  req_ready, wb_valid, wb_tag, wb_data, wb_src
    );

    modport slave (
        input  req_valid, req_tag, req_data, flush, rob_stall,
        output req_ready, wb_valid, wb_tag, wb_data, wb_src
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: one-entry holding buffer per execution unit, one grant per
// cycle onto a registered write-back bus; idle cycles carry TAG_INVALID.
module wb_arbiter #(
    parameter int unsigned     N_REQ       = 4,
    parameter int unsigned     TAG_W       = 4,
    parameter int unsigned     DATA_W      = 32,
    parameter logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}}
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int unsigned     SrcW    = $clog2(N_REQ);
    localparam logic [SrcW-1:0] LastIdx = SrcW'(N_REQ - 1);

    logic [N_REQ-1:0]  buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0]  buf_tag_q  [N_REQ];
    logic [TAG_W-1:0]  buf_tag_d  [N_REQ];
    logic [DATA_W-1:0] buf_data_q [N_REQ];
    logic [DATA_W-1:0] buf_data_d [N_REQ];
    logic [SrcW-1:0]   rr_ptr_q, rr_ptr_d;

    logic              wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [SrcW-1:0]   wb_src_q, wb_src_d;

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  req_ready;
    logic              grant_any;
    logic [SrcW-1:0]   grant_idx;

    always_comb begin
        elig = buf_valid_q & ~{N_REQ{bus.rob_stall | bus.flush}};
    end

    // First eligible buffer scanning upward from rr_ptr, wrapping.
    always_comb begin
        int unsigned k;
        k         = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            k = (32'(rr_ptr_q) + j) % N_REQ;
            if (!grant_any && elig[k]) begin
                grant_any = 1'b1;
                grant_idx = SrcW'(k);
                grant[k]  = 1'b1;
            end
        end
    end

    // A granted buffer frees its slot on the same edge, so it can be refilled immediately.
    always_comb begin
        req_ready = {N_REQ{~rst & ~bus.flush}} & (~buf_valid_q | grant);
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
            if (bus.req_valid[i] && req_ready[i] &&
                bus.req_tag[i*TAG_W +: TAG_W] != TAG_INVALID) begin
                buf_valid_d[i] = 1'b1;
                buf_tag_d[i]   = bus.req_tag[i*TAG_W +: TAG_W];
                buf_data_d[i]  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
        if (bus.flush) begin
            buf_valid_d = '0;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wb_valid_d = grant_any;
        wb_tag_d   = TAG_INVALID;
        wb_data_d  = wb_data_q;
        wb_src_d   = wb_src_q;
        if (grant_any) begin
            wb_tag_d  = buf_tag_q[grant_idx];
            wb_data_d = buf_data_q[grant_idx];
            wb_src_d  = grant_idx;
            rr_ptr_d  = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
        end
        if (bus.flush) begin
            rr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= '0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                buf_tag_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= TAG_INVALID;
            wb_data_q  <= '0;
            wb_src_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            rr_ptr_q    <= rr_ptr_d;
            wb_valid_q  <= wb_valid_d;
            wb_tag_q    <= wb_tag_d;
            wb_data_q   <= wb_data_d;
            wb_src_q    <= wb_src_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_tag    = wb_tag_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_src    = wb_src_q;
endmodule
